// File: rtl/fetch.sv
// fetch: instruction fetch (IF) stage.
//   Sends in-order requests to instruction memory. Each request is tagged with
//   its PC. Responses land in a small instruction buffer, and decode takes them
//   through the registered fe_to_de output. When fe_to_de.pc_r is 1, the output
//   is a bubble.
//   Requests in flight plus buffered entries never exceed FIFO_DEPTH, so the
//   buffer can never overflow. A redirect flushes the buffer. Responses still
//   in flight at that point are counted in drop_cnt and discarded as they
//   arrive.
// Optional build macro: FETCH_BYPASS_EN. When it is defined, a response that
//   arrives while the buffer is empty and decode is ready goes straight into
//   fe_to_de. This removes one cycle of latency.
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   en                           decode ready; 0 holds fe_to_de
//   pc_r, redirect_target        redirect from EX and its new PC
//   imem_req_valid/ready/addr    request channel to instruction memory
//   imem_rsp_valid/data          in-order response channel, never stalled
//   fe_to_de                     registered {pc_value, instruction_value, pc_r}

package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc_value;
        logic [31:0] instruction_value;
        logic        pc_r;
    } fe_to_de_s;
endpackage

module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                pc_r,
    input  logic [31:0]         redirect_target,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [31:0]         imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output fetch_pkg::fe_to_de_s fe_to_de
);
    localparam int          CW  = $clog2(FIFO_DEPTH + 1);
    localparam int          PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_fetch;
    logic [CW-1:0] outstanding, fifo_count, drop_cnt;
    logic [PW-1:0] tag_wp, tag_rp, fifo_wp, fifo_rp;
    logic [31:0]   tag_q    [FIFO_DEPTH];
    logic [31:0]   fifo_pc  [FIFO_DEPTH];
    logic [31:0]   fifo_ins [FIFO_DEPTH];

    logic          issue, rsp_keep, bypass, fifo_push, fifo_pop;
    logic [31:0]   rsp_pc;
    logic [CW:0]   credit_used;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
        // Gate with reset_n so no request is raised while reset is held.
        imem_req_valid = reset_n && !pc_r && (credit_used < (CW+1)'(FIFO_DEPTH));
        imem_addr      = pc_fetch;
        issue          = imem_req_valid && imem_req_ready;
        rsp_pc         = tag_q[tag_rp];
        rsp_keep       = imem_rsp_valid && !pc_r && (drop_cnt == '0);
`ifdef FETCH_BYPASS_EN
        bypass         = rsp_keep && en && (fifo_count == '0);
`else
        bypass         = 1'b0;
`endif
        fifo_push      = rsp_keep && !bypass;
        fifo_pop       = en && !pc_r && (fifo_count != '0);
    end

    // Storage arrays need no reset; their counters and pointers carry validity.
    always_ff @(posedge clk) begin
        if (issue)
            tag_q[tag_wp] <= pc_fetch;
        if (fifo_push) begin
            fifo_pc[fifo_wp]  <= rsp_pc;
            fifo_ins[fifo_wp] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_fetch    <= RESET_PC;
            outstanding <= '0;
            fifo_count  <= '0;
            drop_cnt    <= '0;
            tag_wp      <= '0;
            tag_rp      <= '0;
            fifo_wp     <= '0;
            fifo_rp     <= '0;
            fe_to_de    <= '{pc_value: RESET_PC, instruction_value: NOP, pc_r: 1'b1};
        end else begin
            // The tag queue keeps running across redirects. Stale responses
            // still have to pop their tags.
            outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
            if (issue) begin
                tag_wp   <= inc_ptr(tag_wp);
                pc_fetch <= pc_fetch + 32'd4;
            end
            if (imem_rsp_valid)
                tag_rp <= inc_ptr(tag_rp);

            if (pc_r) begin
                pc_fetch        <= redirect_target;
                fifo_count      <= '0;
                fifo_wp         <= '0;
                fifo_rp         <= '0;
                // Every response still owed is stale, including one that
                // arrives this cycle. That one is already excluded here.
                drop_cnt        <= outstanding - CW'(imem_rsp_valid);
                fe_to_de.pc_r   <= 1'b1;
            end else begin
                if (imem_rsp_valid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
                if (fifo_push)
                    fifo_wp <= inc_ptr(fifo_wp);
                if (fifo_pop)
                    fifo_rp <= inc_ptr(fifo_rp);

                if (bypass)
                    fe_to_de <= '{pc_value: rsp_pc, instruction_value: imem_rsp_data, pc_r: 1'b0};
                else if (en) begin
                    if (fifo_count != '0)
                        fe_to_de <= '{pc_value: fifo_pc[fifo_rp],
                                      instruction_value: fifo_ins[fifo_rp], pc_r: 1'b0};
                    else
                        fe_to_de.pc_r <= 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(imem_rsp_valid && outstanding == '0));
            assert (credit_used <= (CW+1)'(FIFO_DEPTH));
            assert (drop_cnt <= outstanding);
        end
    end
`endif

endmodule
